// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings and lane helpers for the MEM-stage load/store sequencer.
package mem_access_ctrl_pkg;

    // Access width codes, shared with the load-data extractor.
    typedef enum logic [2:0] {
        MEM_NO     = 3'd0,
        MEM_DOUBLE = 3'd1,
        MEM_WORD   = 3'd2,
        MEM_HALF   = 3'd3,
        MEM_BYTE   = 3'd4,
        MEM_UNWORD = 3'd5,
        MEM_UNHALF = 3'd6,
        MEM_UNBYTE = 3'd7
    } mem_width_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 8;

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [2:0] width);
        case (width)
            MEM_DOUBLE:           align_mask = 3'b111;
            MEM_WORD, MEM_UNWORD: align_mask = 3'b011;
            MEM_HALF, MEM_UNHALF: align_mask = 3'b001;
            default:              align_mask = 3'b000;
        endcase
    endfunction

    // Byte-lane enables of an access sitting at lane 0.
    function automatic logic [7:0] lane_base(input logic [2:0] width);
        case (width)
            MEM_DOUBLE:           lane_base = 8'hFF;
            MEM_WORD, MEM_UNWORD: lane_base = 8'h0F;
            MEM_HALF, MEM_UNHALF: lane_base = 8'h03;
            default:              lane_base = 8'h01;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_trunc.sv
// DataTrunc: pulls the addressed field out of a 64-bit bus beat and
// sign- or zero-extends it according to the access width.
module mem_access_ctrl_trunc
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]  width,
    input  logic [2:0]  remain,
    input  logic [63:0] rdata,
    output logic [63:0] result
);

    logic [63:0] shifted;

    // Move the addressed byte to lane 0, then extend to 64 bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        shifted = rdata >> {remain, 3'b000};
        result  = '0;
        case (width)
            MEM_DOUBLE: result = shifted;
            MEM_WORD:   result = {{32{shifted[31]}}, shifted[31:0]};
            MEM_HALF:   result = {{48{shifted[15]}}, shifted[15:0]};
            MEM_BYTE:   result = {{56{shifted[7]}},  shifted[7:0]};
            MEM_UNWORD: result = {32'd0, shifted[31:0]};
            MEM_UNHALF: result = {48'd0, shifted[15:0]};
            MEM_UNBYTE: result = {56'd0, shifted[7:0]};
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and the data-memory bus:
// alignment check, one valid/ready transaction per access, pipeline stall,
// extended load return and a bus timeout guard.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [2:0]  width,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wmask,
    input  logic        bus_ready,
    input  logic [63:0] bus_rdata,
    output logic        stall,
    output logic        done,
    output logic [63:0] load_data,
    output logic        misalign,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       width_q;
    logic [2:0]       off_q;
    logic             start, aligned;
    logic             issue, handshake, timeout;
    logic             stall_c, misalign_c;
    logic [63:0]      trunc_data;

    assign start   = (mem_re | mem_we) && (width != MEM_NO);
    assign aligned = (addr[2:0] & align_mask(width)) == 3'b000;

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        handshake  = 1'b0;
        timeout    = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && aligned) begin
                    issue   = 1'b1;
                    stall_c = 1'b1;
                    state_d = ST_REQ;
                end else if (start) begin
                    misalign_c = 1'b1;
                end
            end
            ST_REQ: begin
                stall_c = 1'b1;
                if (bus_ready) begin
                    handshake = 1'b1;
                    state_d   = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = ST_DONE;
                end
            end
            // The instruction still presented here has already completed.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // While reset is held the outputs read zero even if the MEM stage is still requesting.
    assign stall    = rstn & stall_c;
    assign misalign = rstn & misalign_c;
    assign bus_req  = (state_q == ST_REQ);
    assign done     = (state_q == ST_DONE);

    mem_access_ctrl_trunc u_trunc (
        .width  (width_q),
        .remain (off_q),
        .rdata  (bus_rdata),
        .result (trunc_data)
    );

    // State, latched access fields, timeout counter and load result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            width_q   <= MEM_NO;
            off_q     <= 3'd0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= 8'h00;
            bus_err   <= 1'b0;
            load_data <= '0;
        end else begin
            // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            bus_err <= timeout;
            if (issue) begin
                cnt_q     <= '0;
                width_q   <= width;
                off_q     <= addr[2:0];
                bus_we    <= mem_we;
                bus_addr  <= {addr[63:3], 3'b000};
                bus_wdata <= mem_we ? (wdata << {addr[2:0], 3'b000}) : 64'd0;
                bus_wmask <= mem_we ? (lane_base(width) << addr[2:0]) : 8'h00;
            end else if (state_q == ST_REQ && !bus_ready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (handshake && !bus_we) begin
                load_data <= trunc_data;
            end else if (timeout) begin
                load_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus randomized
// accesses compared against a spec-level model of lanes, extension and timing.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        mem_re, mem_we;
    logic [2:0]  width;
    logic [63:0] addr, wdata;
    logic        bus_req, bus_we;
    logic [63:0] bus_addr, bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_ready;
    logic [63:0] bus_rdata;
    logic        stall, done, misalign, bus_err;
    logic [63:0] load_data;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_load = '0;

    mem_access_ctrl #(.TIMEOUT(TMO)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .width     (width),
        .addr      (addr),
        .wdata     (wdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wmask (bus_wmask),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata),
        .stall     (stall),
        .done      (done),
        .load_data (load_data),
        .misalign  (misalign),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    function automatic int size_of(input logic [2:0] w);
        case (w)
            3'd1:       return 8;
            3'd2, 3'd5: return 4;
            3'd3, 3'd6: return 2;
            default:    return 1;
        endcase
    endfunction

    // Spec-level extraction: shift the addressed bytes down, mask, extend.
    function automatic logic [63:0] model_load(input logic [2:0] w, input int off, input logic [63:0] rd);
        logic [63:0] v, m;
        int sz;
        sz = size_of(w);
        v  = rd >> (8 * off);
        m  = (sz == 8) ? {64{1'b1}} : ((64'd1 << (8 * sz)) - 64'd1);
        v  = v & m;
        if (w <= 3'd4 && v[8 * sz - 1]) v = v | ~m;
        return v;
    endfunction

    task automatic idle_inputs();
        mem_re = 1'b0; mem_we = 1'b0; width = 3'd0; addr = '0; wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
    endtask

    // One MEM-stage access with the bus answering after `delay` wait cycles.
    task automatic do_access(input logic re, input logic we, input logic [2:0] w,
                             input logic [63:0] a, input logic [63:0] wd,
                             input logic [63:0] rd, input int delay, input string tag);
        int sz, off, req_cycles, exp_req;
        bit st, al, tmo, finished;
        logic [63:0] exp_addr, exp_wdata, exp_wmask64;
        logic [7:0]  exp_wmask;
        sz  = size_of(w);
        off = int'(a[2:0]);
        st  = (re || we) && (w != 3'd0);
        al  = (off % sz) == 0;
        tmo = delay >= TMO;
        exp_req     = tmo ? TMO : delay + 1;
        exp_addr    = a - 64'(off);
        exp_wmask64 = we ? (((64'd1 << sz) - 64'd1) << off) : 64'd0;
        exp_wmask   = exp_wmask64[7:0];
        exp_wdata   = wd << (8 * off);

        @(negedge clk);
        mem_re = re; mem_we = we; width = w; addr = a; wdata = wd;
        bus_ready = 1'b0; bus_rdata = {$urandom, $urandom};
        #1;
        if (!st || !al) begin
            checks++;
            if ({stall, misalign, bus_req, done} !== {1'b0, st, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s idle-cycle {stall,misalign,req,done} got %b want %b",
                         tag, {stall, misalign, bus_req, done}, {1'b0, st, 1'b0, 1'b0});
            end
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if ({bus_req, done, misalign, load_data} !== {3'b000, exp_load}) begin
                errors++;
                $display("FAIL %s no-issue follow-up req=%b done=%b mis=%b ld=%h want ld=%h",
                         tag, bus_req, done, misalign, load_data, exp_load);
            end
            return;
        end

        checks++;
        if ({stall, misalign, bus_req, done} !== 4'b1000) begin
            errors++;
            $display("FAIL %s issue-cycle {stall,misalign,req,done} got %b want 1000",
                     tag, {stall, misalign, bus_req, done});
        end

        req_cycles = 0;
        finished   = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            @(negedge clk);
            bus_ready = 1'b0;
            bus_rdata = {$urandom, $urandom};
            #1;
            if (bus_req) begin
                checks++;
                if ({stall, done, bus_addr, bus_we, bus_wmask} !== {2'b10, exp_addr, we, exp_wmask}
                    || (we && bus_wdata !== exp_wdata)) begin
                    errors++;
                    $display("FAIL %s req-fields stall=%b done=%b addr=%h we=%b mask=%h wd=%h want addr=%h we=%b mask=%h wd=%h",
                             tag, stall, done, bus_addr, bus_we, bus_wmask, bus_wdata,
                             exp_addr, we, exp_wmask, exp_wdata);
                end
                if (req_cycles == delay) begin
                    bus_ready = 1'b1;
                    bus_rdata = rd;
                end
                req_cycles++;
            end else begin
                finished = 1'b1;
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL %s bus_req never dropped within 40 cycles", tag);
            idle_inputs();
            return;
        end

        if (tmo) exp_load = '0;
        else if (!we) exp_load = model_load(w, off, rd);
        checks++;
        if (req_cycles !== exp_req || {done, stall, bus_err, misalign} !== {2'b10, tmo, 1'b0}
            || load_data !== exp_load) begin
            errors++;
            $display("FAIL %s completion req_cycles=%0d done=%b stall=%b err=%b mis=%b ld=%h want req_cycles=%0d err=%b ld=%h",
                     tag, req_cycles, done, stall, bus_err, misalign, load_data, exp_req, tmo, exp_load);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, stall, done, load_data, misalign, bus_err} !== '0) begin
            errors++;
            $display("FAIL reset outputs req=%b we=%b addr=%h wd=%h mask=%h stall=%b done=%b ld=%h mis=%b err=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_wmask, stall, done, load_data, misalign, bus_err);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        do_access(1'b1, 1'b0, 3'd4, 64'h1003, '0, 64'h0000_0000_8000_0000, 0, "load_byte");
        do_access(1'b1, 1'b0, 3'd6, 64'h2006, '0, 64'hBEEF_0000_0000_0000, 0, "load_unhalf");
        do_access(1'b0, 1'b1, 3'd2, 64'h3004, 64'h1234_5678, '0, 3, "store_word_wait3");
        do_access(1'b1, 1'b0, 3'd3, 64'h4001, '0, '0, 0, "misalign_half");
        do_access(1'b1, 1'b0, 3'd1, 64'h4008, '0, 64'hDEAD_BEEF_CAFE_F00D, 1, "load_double");
        do_access(1'b1, 1'b0, 3'd2, 64'h4010, '0, 64'h1111_2222_3333_4444, 99, "load_timeout");
        do_access(1'b1, 1'b1, 3'd1, 64'h5000, 64'hA5A5_5A5A_0F0F_F0F0, '0, 0, "both_double_store");
        do_access(1'b1, 1'b0, 3'd0, 64'h5008, '0, '0, 0, "width_none");
        do_access(1'b1, 1'b0, 3'd7, 64'h5007, '0, 64'h80FF_FFFF_FFFF_FFFF, 0, "load_unbyte_top");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_re = 1'b1; mem_we = 1'b0; width = 3'd2; addr = 64'h6000; bus_ready = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid reach-REQ bus_req=%b want 1", bus_req);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus_req, stall, done, load_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid async-drop req=%b stall=%b done=%b ld=%h want all 0",
                     bus_req, stall, done, load_data);
        end
        exp_load = '0;
        @(negedge clk);
        idle_inputs();
        rstn = 1'b1;
        do_access(1'b1, 1'b0, 3'd5, 64'h6004, '0, 64'h8765_4321_0000_0000, 0, "after_reset_unword");
    endtask

    task automatic test_random();
        logic [63:0] a;
        for (int i = 0; i < 200; i++) begin
            a = {$urandom, $urandom};
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      a, {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, TMO + 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid();
        test_random();
        @(negedge clk);
        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the MEM pipeline stage and the data-memory bus.
- Accepts one access per instruction and checks alignment.
- Drives a valid/ready bus transaction, with byte-lane mask and shifted write data for stores.
- Stalls the pipeline until completion, then returns sign/zero-extended load data through the DataTrunc extractor, with a bus timeout guard.

Parameters:
- TIMEOUT, 16: max cycles REQ waits for bus_ready before aborting with bus_err; legal range 2..255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- mem_re  in  1  MEM stage requests a load.
- mem_we  in  1  MEM stage requests a store.
- width  in  3  0 none, 1 double, 2 word, 3 half, 4 byte, 5 unword, 6 unhalf, 7 unbyte.
- addr  in  64  byte address.
- wdata  in  64  store data, right-justified.
- bus_req  out  1  transaction valid.
- bus_we  out  1  1 = write.
- bus_addr  out  64  {addr[63:3],3'b000}.
- bus_wdata  out  64  lane-shifted store data.
- bus_wmask  out  8  byte-lane enables; 0 on reads.
- bus_ready  in  1  memory accepts/completes the transaction this cycle.
- bus_rdata  in  64  read data, valid when bus_req and bus_ready are both high.
- stall  out  1  hold the pipeline.
- done  out  1  one-cycle completion pulse.
- load_data  out  64  extended load result, held until next load completes.
- misalign  out  1  one-cycle alignment-fault pulse.
- bus_err  out  1  one-cycle timeout pulse, coincident with done.

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0, load_data 0.
- rstn low mid-transaction drops bus_req immediately, without waiting for a clock edge.
- start = (mem_re|mem_we) && width!=0.
- If mem_re and mem_we are both high, the access is a store.
- Size: 8 for width 1; 4 for 2/5; 2 for 3/6; 1 for 4/7.
- aligned = addr[2:0] % size == 0.
- States:
  - IDLE: if start && aligned, latch op/width/offset/bus fields and go to REQ. stall is 1 this cycle (combinational).
  - IDLE, start && !aligned: misalign=1 for this cycle, stall=0, no bus activity, stay IDLE.
  - REQ: bus_req=1. bus_addr, bus_we, bus_wdata and bus_wmask are registered and stable until handshake. stall=1.
  - REQ, on bus_ready=1 (handshake): for a load, register the truncated result into load_data. Go to DONE.
  - REQ, bus_ready=0: increment counter. When counter reaches TIMEOUT-1 and bus_ready is still 0, drop bus_req, set load_data=0, go to DONE with bus_err.
  - DONE: done=1, bus_err as flagged, stall=0 so the pipeline advances on this edge. Go to IDLE. The same instruction still at the inputs in this cycle is never re-issued.
- stall = (IDLE && start && aligned) || REQ.
- Minimum latency with a zero-wait bus: 2 stall cycles, then done in the 3rd cycle.
- Store mask: bus_wmask = base << addr[2:0], with base 0x01/0x03/0x0F/0xFF by size. bus_wdata = wdata << (8*addr[2:0]).
- Load result = DataTrunc(width, addr[2:0], bus_rdata):
  - width 1..4 sign-extend.
  - width 5..7 zero-extend.
- Counter clears on entry to REQ. It is 8 bits wide; no wrap is possible given TIMEOUT ≤ 255.

Decomposition:
- Shared package/header:
  - Width encodings MEM_NO..MEM_UNBYTE (same values as DataTrunc).
  - State encodings ST_IDLE=2'd0, ST_REQ=2'd1, ST_DONE=2'd2.
- Sub-module: one instance of the existing DataTrunc load extractor (width, remain=latched offset, rdata=bus_rdata). Its output is registered here into load_data.

Test Plan:
- Load byte at addr 0x1003, zero-wait bus, bus_rdata=0x0000_0000_8000_0000 -> bus_addr=0x1000, bus_wmask=0. Cycle 2 done=1, load_data=0xFFFF_FFFF_FFFF_FF80, stall high exactly 2 cycles.
- Unsigned half load at addr 0x2006, bus_rdata=0xBEEF_0000_0000_0000 -> load_data=0x0000_0000_0000_BEEF.
- Store word at addr 0x3004, wdata=0x1234_5678, bus_ready delayed 3 cycles:
  - While waiting: bus_wmask=0xF0, bus_wdata=0x1234_5678_0000_0000, fields stable.
  - Response: done after handshake, stall=1 through REQ.
- Half load at addr 0x4001 -> misalign pulses 1 cycle, bus_req never rises, stall=0.
- TIMEOUT=4, bus_ready tied 0 on a load -> bus_req high 4 cycles then low. done=1 and bus_err=1 together, load_data=0.
- rstn pulled low while in REQ -> bus_req, stall and done go 0 immediately. After release, the next start issues normally.
- Simultaneous mem_re=mem_we=1, double at 0x5000 -> bus_we=1, bus_wmask=0xFF.
